snn_input_loader: RTL and testbench

Upstream stage of `snn_core`. It receives the 784-pixel binary image as 98 bytes from the UART receiver and unpacks each byte into a 784×1 input-unit RAM, one bit per cycle. It serves the core's synchronous read port (`addr_input_unit` → `q_input`) and issues the single-cycle `start` pulse once the full image is stored. It then blocks further loading until the core reports `done`.

---
 rtl/snn_input_loader_if.sv | 13 +
 rtl/snn_input_loader.sv | 93 +++++++++
 tb/tb_snn_input_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/snn_input_loader_if.sv
// snn_input_loader_if: UART byte input, core read port and start/done handshake of the input loader.
interface snn_input_loader_if;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic [9:0] addr_input_unit;
   logic       done;
   logic       q_input;
   logic       start;
   logic       busy;
   logic       ovr;
   modport master(output rx_rdy, rx_data, addr_input_unit, done, input q_input, start, busy, ovr);
   modport slave(input rx_rdy, rx_data, addr_input_unit, done, output q_input, start, busy, ovr);
endinterface

// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks received image bytes LSB-first into a 1-bit RAM and launches snn_core.
module snn_input_loader #(
   parameter int NUM_PIX   = 784,
   parameter int NUM_BYTES = 98
) (
   input logic clk,
   input logic rst_n,
   snn_input_loader_if.slave bus
);
   localparam logic [9:0] LAST = 10'(NUM_BYTES * 8 - 1);
   typedef enum logic [2:0] {IDLE, SHIFT, WAIT, START, RUN} state_t;
   state_t     state, state_d;
   logic [7:0] shft, pend;
   logic       pend_vld, ovr, q;
   logic [9:0] wr_addr;
   logic [2:0] bit_cnt;
   logic       we, ld_rx, ld_pend, cap, drop, last_bit, last_pix;
   logic       mem [NUM_PIX];
   assign last_bit = bit_cnt == 3'd7;
   assign last_pix = wr_addr == LAST;
   always_comb begin
      state_d = state;
      we      = 1'b0;
      ld_rx   = 1'b0;
      ld_pend = 1'b0;
      cap     = 1'b0;
      drop    = 1'b0;
      case (state)
         IDLE, WAIT: begin
            ld_rx   = bus.rx_rdy;
            state_d = bus.rx_rdy ? SHIFT : state;
         end
         SHIFT: begin
            we = 1'b1;
            // a byte held in pend when the image completes is discarded as an overrun
            if (last_bit && last_pix) begin
               state_d = START;
               drop    = pend_vld | bus.rx_rdy;
            end else if (last_bit) begin
               ld_pend = pend_vld;
               ld_rx   = !pend_vld && bus.rx_rdy;
               drop    = pend_vld && bus.rx_rdy;
               state_d = (pend_vld || bus.rx_rdy) ? SHIFT : WAIT;
            end else begin
               cap  = bus.rx_rdy && !pend_vld;
               drop = bus.rx_rdy && pend_vld;
            end
         end
         START: begin
            state_d = RUN;
            drop    = bus.rx_rdy;
         end
         RUN: begin
            drop    = bus.rx_rdy;
            state_d = bus.done ? IDLE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         shft     <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
         wr_addr  <= '0;
         bit_cnt  <= '0;
         ovr      <= 1'b0;
         q        <= 1'b0;
      end else begin
         state <= state_d;
         q     <= mem[bus.addr_input_unit];
         if (drop) ovr <= 1'b1;
         if (ld_rx) shft <= bus.rx_data;
         else if (ld_pend) shft <= pend;
         else if (we) shft <= {1'b0, shft[7:1]};
         if (cap) begin
            pend     <= bus.rx_data;
            pend_vld <= 1'b1;
         end else if (ld_pend || state_d == START) pend_vld <= 1'b0;
         if (we) begin
            wr_addr <= (last_bit && last_pix) ? '0 : wr_addr + 10'd1;
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   // RAM is never reset; partial images are simply overwritten by the next load
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= shft[0];
   assign bus.q_input = q;
   assign bus.start   = state == START;
   assign bus.busy    = state != IDLE;
   assign bus.ovr     = ovr;
endmodule

// File: tb/tb_snn_input_loader.sv
// tb_snn_input_loader: table vectors, hand sequences and a randomized image against an arrival-time model.
module tb_snn_input_loader;
   localparam int NB = 98;
   localparam int NP = 784;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   snn_input_loader_if bus();
   snn_input_loader #(.NUM_PIX(NP), .NUM_BYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #10 clk = ~clk;

   typedef struct {
      string       name;
      logic [23:0] b;
      int          g1;
      int          g2;
      logic        ovr;
      logic [15:0] bits;
   } vec_t;
   vec_t vt[5];

   int   checks = 0, errors = 0, cyc = 0;
   int   n_start = 0, s_obs = -1, last = 0, guard = 0;
   bit   mm [NP];
   logic m_busy = 1'b0, m_ovr = 1'b0;
   int   acc = 0, ps = -1000, e = -1000, m_start = -1;

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic mreset();
      m_busy = 1'b0; m_ovr = 1'b0; acc = 0; ps = -1000; e = -1000; m_start = -1;
   endtask

   // each accepted byte occupies 8 write cycles starting after the arrival or after the previous byte
   task automatic model(input logic r, input logic [7:0] d, input logic dn);
      int s;
      if (r && !m_busy) begin acc = 0; ps = cyc; e = cyc; end
      if (r && (acc == NB || ps > cyc)) m_ovr = 1'b1;
      else if (r) begin
         s  = (cyc >= e) ? cyc + 1 : e + 1;
         ps = s;
         e  = s + 7;
         for (int j = 0; j < 8; j++) mm[8 * acc + j] = d[j];
         acc++;
         if (acc == NB) m_start = e + 1;
      end
      if (r) m_busy = 1'b1;
      if (dn && m_busy && acc == NB && cyc > m_start) m_busy = 1'b0;
   endtask

   task automatic step(input logic r, input logic [7:0] d, input logic dn);
      logic eb, es;
      bus.rx_rdy = r; bus.rx_data = d; bus.done = dn;
      eb = m_busy;
      es = cyc == m_start;
      if (rst_n) model(r, d, dn);
      @(negedge clk);
      chkb("busy", bus.busy, eb);
      chkb("start", bus.start, es);
      if (bus.start) begin n_start++; s_obs = cyc; end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic rd(input int a, input logic exp, input string nm);
      bus.addr_input_unit = 10'(a);
      step(1'b0, 8'h00, 1'b0);
      chkb($sformatf("%s[%0d]", nm, a), bus.q_input, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mreset();
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic sweep_img1(input string nm);
      logic [7:0] bv;
      for (int a = 0; a < NP; a++) begin
         bv = 8'(a / 8);
         rd(a, bv[a % 8], nm);
      end
   endtask

   initial begin
      vt[0] = '{"b2b",      24'h003CA5, 3, 0, 1'b0, 16'h3CA5};
      vt[1] = '{"ovrun",    24'h332211, 2, 2, 1'b1, 16'h2211};
      vt[2] = '{"gap9",     24'h0000FF, 9, 0, 1'b0, 16'h00FF};
      vt[3] = '{"lastbit",  24'h000180, 8, 0, 1'b0, 16'h0180};
      vt[4] = '{"pendfull", 24'h99C35A, 1, 7, 1'b1, 16'hC35A};
      bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.addr_input_unit = '0; bus.done = 1'b0;
      @(posedge clk); #1;
      chkb("rst_q", bus.q_input, 1'b0);
      chkb("rst_ovr", bus.ovr, 1'b0);
      do_reset();
      foreach (vt[i]) begin
         do_reset();
         step(1'b1, vt[i].b[7:0], 1'b0);
         repeat (vt[i].g1 - 1) step(1'b0, 8'h00, 1'b0);
         step(1'b1, vt[i].b[15:8], 1'b0);
         if (vt[i].g2 > 0) begin
            repeat (vt[i].g2 - 1) step(1'b0, 8'h00, 1'b0);
            step(1'b1, vt[i].b[23:16], 1'b0);
         end
         repeat (20) step(1'b0, 8'h00, 1'b0);
         chkb({vt[i].name, "_ovr"}, bus.ovr, vt[i].ovr);
         for (int a = 0; a < 16; a++) rd(a, vt[i].bits[a], vt[i].name);
      end
      // reset mid-SHIFT with ovr and q_input both high beforehand
      rd(1, 1'b1, "pre_rst");
      step(1'b1, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      mreset();
      #1;
      chkb("rst_mid_q", bus.q_input, 1'b0);
      chkb("rst_mid_start", bus.start, 1'b0);
      chkb("rst_mid_busy", bus.busy, 1'b0);
      chkb("rst_mid_ovr", bus.ovr, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 8'hFF, 1'b0);
      repeat (10) step(1'b0, 8'h00, 1'b0);
      for (int a = 0; a < 8; a++) rd(a, 1'b1, "after_rst");
      chkb("after_rst_ovr", bus.ovr, 1'b0);
      // full image, byte i = i, with done pulses during loading that must be ignored
      do_reset();
      for (int i = 0; i < NB; i++) begin
         last = cyc;
         step(1'b1, 8'(i), 1'b0);
         repeat (19) step(1'b0, 8'h00, i == 50);
      end
      for (int k = 0; k < 40 && n_start == 0; k++) step(1'b0, 8'h00, 1'b0);
      chki("start_latency", s_obs - last, 9);
      repeat (5) step(1'b0, 8'h00, 1'b0);
      chki("start_count1", n_start, 1);
      chkb("img1_ovr", bus.ovr, 1'b0);
      sweep_img1("img1");
      step(1'b1, 8'hFF, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      chkb("run_byte_ovr", bus.ovr, 1'b1);
      sweep_img1("img1_after_run_byte");
      while (cyc < s_obs + 2000) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chkb("busy_fall", bus.busy, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      // second image: random bytes at random spacing, overlaps and drops included
      guard = 0;
      while ((acc < NB || !m_busy) && guard < 3000) begin
         step(1'b1, 8'($urandom), 1'b0);
         repeat ($urandom_range(0, 11)) step(1'b0, 8'h00, 1'b0);
         guard++;
      end
      chkb("img2_loaded", guard < 3000, 1'b1);
      for (int k = 0; k < 200 && n_start < 2; k++) step(1'b0, 8'h00, cyc == m_start);
      chki("start_count2", n_start, 2);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      chkb("done_in_start_ignored", bus.busy, 1'b1);
      chkb("img2_ovr", bus.ovr, m_ovr);
      for (int a = 0; a < NP; a++) rd(a, mm[a], "img2");
      step(1'b0, 8'h00, 1'b1);
      chkb("busy_fall2", bus.busy, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
